regfile_mp_sb: RTL and testbench

Parametrised multi-port register file for the next single/multi-cycle CPU core. It adds the following to the basic 2-read/1-write file:
- N read ports
- Two prioritised write ports: ALU writeback and load writeback
- Optional write-to-read bypass and optional hardwired-zero R0
- A per-register pending-write scoreboard for multi-cycle loads
- A sequenced bulk-clear engine
It sits between the decode stage (reads, scoreboard query) and the writeback stage (W0/W1).

---
 rtl/cpu_pkg.sv | 18 +
 rtl/regfile_rd_port.sv | 42 ++++
 rtl/regfile_mp_sb.sv | 143 ++++++++++++++
 tb/tb_regfile_mp_sb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU core definitions.
// Default widths, sweep FSM encoding and flat-vector slicing helper.
package cpu_pkg;

    localparam int ADDR_DEF = 5;
    localparam int SIZE_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_st_t;

    // Low bit index of element k in a flat vector of w-bit elements.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One register file read port.
// Address decode, write-to-read bypass and R0 forcing.
module regfile_rd_port
    import cpu_pkg::*;
#(
    parameter int ADDR    = ADDR_DEF,
    parameter int SIZE    = SIZE_DEF,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic [(1<<ADDR)*SIZE-1:0] i_regs,
    input  logic [ADDR-1:0]           i_addr,
    input  logic                      i_byp_en,
    input  logic                      i_w0_en,
    input  logic [ADDR-1:0]           i_w0_addr,
    input  logic [SIZE-1:0]           i_w0_data,
    input  logic                      i_w1_en,
    input  logic [ADDR-1:0]           i_w1_addr,
    input  logic [SIZE-1:0]           i_w1_data,
    output logic [SIZE-1:0]           o_data
);

    logic w_hit0;
    logic w_hit1;

    assign w_hit0 = i_w0_en && (i_w0_addr == i_addr);
    assign w_hit1 = i_w1_en && (i_w1_addr == i_addr);

    // Stored value, overridden by same-cycle write data, then R0 forcing.
    always_comb begin
        o_data = i_regs[i_addr*SIZE +: SIZE];
        if ((BYPASS != 0) && i_byp_en) begin
            if (w_hit1)
                o_data = i_w1_data;
            else if (w_hit0)
                o_data = i_w0_data;
        end
        if ((ZERO_R0 != 0) && (i_addr == '0))
            o_data = '0;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with load scoreboard.
// Two prioritised write ports and a sequenced bulk-clear engine.
module regfile_mp_sb
    import cpu_pkg::*;
#(
    parameter int ADDR    = ADDR_DEF,
    parameter int SIZE    = SIZE_DEF,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [NRD*ADDR-1:0] R_Addr,
    output logic [NRD*SIZE-1:0] R_Data,
    output logic [NRD-1:0]      R_Pend,
    input  logic                W0_En,
    input  logic [ADDR-1:0]     W0_Addr,
    input  logic [SIZE-1:0]     W0_Data,
    input  logic                W1_En,
    input  logic [ADDR-1:0]     W1_Addr,
    input  logic [SIZE-1:0]     W1_Data,
    input  logic                Pend_Set,
    input  logic [ADDR-1:0]     Pend_Addr,
    input  logic                Sweep_Req,
    output logic                Busy
);

    localparam int NUMB = 1 << ADDR;

    logic [SIZE-1:0]      r_reg [NUMB];
    logic [NUMB-1:0]      r_pend;
    logic [ADDR-1:0]      r_cnt;
    sweep_st_t            r_state;
    sweep_st_t            w_state_nx;
    logic [NUMB*SIZE-1:0] w_regs;
    logic                 w_start;
    logic                 w_wr_ok;
    logic                 w_w0_ok;
    logic                 w_w1_ok;
    logic                 w_ps_ok;

    assign Busy    = (r_state == SWEEP);
    assign w_start = (r_state == IDLE) && Sweep_Req;
    // The request edge itself drops any write or pend-set.
    assign w_wr_ok = (r_state == IDLE) && !Sweep_Req;
    assign w_w0_ok = W0_En && !((ZERO_R0 != 0) && (W0_Addr == '0));
    assign w_w1_ok = W1_En && !((ZERO_R0 != 0) && (W1_Addr == '0));
    assign w_ps_ok = Pend_Set
                   && !((ZERO_R0 != 0) && (Pend_Addr == '0));

    // Register array: reset pattern, sweep clearing, W1-over-W0 writes.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int i = 0; i < NUMB; i++)
                r_reg[i] <= SIZE'(i);
        end else if (r_state == SWEEP) begin
            r_reg[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            if (w_w0_ok)
                r_reg[W0_Addr] <= W0_Data;
            if (w_w1_ok)
                r_reg[W1_Addr] <= W1_Data;
        end
    end

    // Scoreboard: load writeback clears, a new load issue wins.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_pend <= '0;
        end else if (w_start) begin
            r_pend <= '0;
        end else if (w_wr_ok) begin
            if (W1_En)
                r_pend[W1_Addr] <= 1'b0;
            if (w_ps_ok)
                r_pend[Pend_Addr] <= 1'b1;
        end
    end

    // Sweep state register and address counter.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_start)
                r_cnt <= '0;
            else if (r_state == SWEEP)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Next state: counter wrap ends the sweep.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:
                if (Sweep_Req)
                    w_state_nx = SWEEP;
            SWEEP:
                if (r_cnt == '1)
                    w_state_nx = IDLE;
            default:
                w_state_nx = IDLE;
        endcase
    end

    genvar g;

    generate
        for (g = 0; g < NUMB; g++) begin : g_flat
            assign w_regs[g*SIZE +: SIZE] = r_reg[g];
        end

        for (g = 0; g < NRD; g++) begin : g_rd
            logic [ADDR-1:0] w_ra;

            assign w_ra = R_Addr[slice_lo(g, ADDR) +: ADDR];
            assign R_Pend[g] = r_pend[w_ra];

            regfile_rd_port #(
                .ADDR    (ADDR),
                .SIZE    (SIZE),
                .ZERO_R0 (ZERO_R0),
                .BYPASS  (BYPASS)
            ) u_rd (
                .i_regs    (w_regs),
                .i_addr    (w_ra),
                .i_byp_en  (!Busy),
                .i_w0_en   (W0_En),
                .i_w0_addr (W0_Addr),
                .i_w0_data (W0_Data),
                .i_w1_en   (W1_En),
                .i_w1_addr (W1_Addr),
                .i_w1_data (W1_Data),
                .o_data    (R_Data[slice_lo(g, SIZE) +: SIZE])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb.
// Directed vector table plus sweep and reset-mid-sweep sequences.
module tb_regfile_mp_sb;

    logic        Clk;
    logic        Clr;
    logic [9:0]  R_Addr;
    logic [63:0] R_Data;
    logic [1:0]  R_Pend;
    logic        W0_En;
    logic [4:0]  W0_Addr;
    logic [31:0] W0_Data;
    logic        W1_En;
    logic [4:0]  W1_Addr;
    logic [31:0] W1_Data;
    logic        Pend_Set;
    logic [4:0]  Pend_Addr;
    logic        Sweep_Req;
    logic        Busy;

    int n_chk;
    int n_fail;

    regfile_mp_sb u_dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .R_Addr    (R_Addr),
        .R_Data    (R_Data),
        .R_Pend    (R_Pend),
        .W0_En     (W0_En),
        .W0_Addr   (W0_Addr),
        .W0_Data   (W0_Data),
        .W1_En     (W1_En),
        .W1_Addr   (W1_Addr),
        .W1_Data   (W1_Data),
        .Pend_Set  (Pend_Set),
        .Pend_Addr (Pend_Addr),
        .Sweep_Req (Sweep_Req),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        w0_en;
        logic [4:0]  w0_a;
        logic [31:0] w0_d;
        logic        w1_en;
        logic [4:0]  w1_a;
        logic [31:0] w1_d;
        logic        ps;
        logic [4:0]  pa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  p;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(
        input logic        w0e, input logic [4:0] w0a,
        input logic [31:0] w0d,
        input logic        w1e, input logic [4:0] w1a,
        input logic [31:0] w1d,
        input logic        ps,  input logic [4:0] pa,
        input logic [4:0]  ra0, input logic [4:0] ra1,
        input logic [31:0] d0,  input logic [31:0] d1,
        input logic [1:0]  p);
        vec_t v;
        v.w0_en = w0e; v.w0_a = w0a; v.w0_d = w0d;
        v.w1_en = w1e; v.w1_a = w1a; v.w1_d = w1d;
        v.ps = ps; v.pa = pa;
        v.ra0 = ra0; v.ra1 = ra1;
        v.d0 = d0; v.d1 = d1; v.p = p;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     nm, act, exp);
        end
    endtask

    task automatic idle_in();
        W0_En = 1'b0; W0_Addr = '0; W0_Data = '0;
        W1_En = 1'b0; W1_Addr = '0; W1_Data = '0;
        Pend_Set = 1'b0; Pend_Addr = '0;
        Sweep_Req = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0,
                      input logic [4:0] a1);
        R_Addr = {a1, a0};
    endtask

    int n;

    initial begin
        Clr = 1'b1;
        n_chk = 0;
        n_fail = 0;
        idle_in();
        rd(5'd0, 5'd5);

        //        w0         w1          pset   ra      d0/d1   p
        vecs[0]  = mk(0,0,0, 0,0,0, 0,0, 0,5,
                      32'd0, 32'd5, 2'b00);
        vecs[1]  = mk(1,7,32'hDEADBEEF, 0,0,0, 0,0, 7,7,
                      32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
        vecs[2]  = mk(0,0,0, 0,0,0, 0,0, 7,0,
                      32'hDEADBEEF, 32'd0, 2'b00);
        vecs[3]  = mk(1,0,32'h1234, 0,0,0, 0,0, 0,0,
                      32'd0, 32'd0, 2'b00);
        vecs[4]  = mk(0,0,0, 0,0,0, 0,0, 0,6,
                      32'd0, 32'd6, 2'b00);
        vecs[5]  = mk(1,3,32'h11, 1,3,32'h22, 0,0, 3,3,
                      32'h22, 32'h22, 2'b00);
        vecs[6]  = mk(0,0,0, 0,0,0, 0,0, 3,4,
                      32'h22, 32'd4, 2'b00);
        vecs[7]  = mk(0,0,0, 0,0,0, 1,9, 9,9,
                      32'd9, 32'd9, 2'b00);
        vecs[8]  = mk(1,9,32'hAA, 0,0,0, 0,0, 9,8,
                      32'hAA, 32'd8, 2'b01);
        vecs[9]  = mk(0,0,0, 1,9,32'hBB, 1,9, 9,9,
                      32'hBB, 32'hBB, 2'b11);
        vecs[10] = mk(0,0,0, 1,9,32'hCC, 0,0, 9,1,
                      32'hCC, 32'd1, 2'b01);
        vecs[11] = mk(0,0,0, 0,0,0, 0,0, 9,2,
                      32'hCC, 32'd2, 2'b00);
        vecs[12] = mk(0,0,0, 0,0,0, 1,0, 0,0,
                      32'd0, 32'd0, 2'b00);
        vecs[13] = mk(0,0,0, 0,0,0, 0,0, 0,0,
                      32'd0, 32'd0, 2'b00);
        vecs[14] = mk(0,0,0, 1,5,32'h55, 0,0, 5,6,
                      32'h55, 32'd6, 2'b00);
        vecs[15] = mk(0,0,0, 0,0,0, 1,12, 12,13,
                      32'd12, 32'd13, 2'b00);
        vecs[16] = mk(0,0,0, 0,0,0, 0,0, 12,13,
                      32'd12, 32'd13, 2'b01);

        #12;
        @(negedge Clk);
        Clr = 1'b0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);

        for (int i = 0; i < 17; i++) begin
            @(negedge Clk);
            W0_En = vecs[i].w0_en;
            W0_Addr = vecs[i].w0_a;
            W0_Data = vecs[i].w0_d;
            W1_En = vecs[i].w1_en;
            W1_Addr = vecs[i].w1_a;
            W1_Data = vecs[i].w1_d;
            Pend_Set = vecs[i].ps;
            Pend_Addr = vecs[i].pa;
            rd(vecs[i].ra0, vecs[i].ra1);
            #1;
            chk($sformatf("v%0d_d0", i),
                R_Data[31:0], vecs[i].d0);
            chk($sformatf("v%0d_d1", i),
                R_Data[63:32], vecs[i].d1);
            chk($sformatf("v%0d_pend", i),
                32'(R_Pend), 32'(vecs[i].p));
        end

        // Sweep: busy length, ignored write, no bypass.
        @(negedge Clk);
        idle_in();
        Sweep_Req = 1'b1;
        #1;
        chk("sw_req_busy", 32'(Busy), 32'd0);
        @(posedge Clk);
        #1;
        Sweep_Req = 1'b0;
        n = 0;
        while (Busy && n < 40) begin
            if (n == 5) begin
                W0_En = 1'b1;
                W0_Addr = 5'd31;
                W0_Data = 32'hCAFE0001;
                rd(5'd31, 5'd12);
                #1;
                chk("sw_nobyp", R_Data[31:0], 32'd31);
                chk("sw_pend12", 32'(R_Pend), 32'd0);
            end
            @(posedge Clk);
            #1;
            W0_En = 1'b0;
            n++;
        end
        chk("sw_busy_len", 32'(n), 32'd32);
        @(negedge Clk);
        for (int a = 0; a < 32; a += 2) begin
            rd(5'(a), 5'(a + 1));
            #1;
            chk($sformatf("sw_r%0d", a),
                R_Data[31:0], 32'd0);
            chk($sformatf("sw_r%0d", a + 1),
                R_Data[63:32], 32'd0);
            chk($sformatf("sw_p%0d", a),
                32'(R_Pend), 32'd0);
        end

        // Reset in the middle of a sweep.
        @(negedge Clk);
        Sweep_Req = 1'b1;
        @(posedge Clk);
        #1;
        Sweep_Req = 1'b0;
        n = 0;
        while (Busy && n < 10) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("mid_cnt", 32'(n), 32'd10);
        #1;
        Clr = 1'b1;
        #1;
        chk("mid_busy", 32'(Busy), 32'd0);
        rd(5'd20, 5'd0);
        #1;
        chk("mid_r20", R_Data[31:0], 32'd20);
        chk("mid_r0", R_Data[63:32], 32'd0);
        @(negedge Clk);
        Clr = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("post_busy", 32'(Busy), 32'd0);
        for (int a = 0; a < 32; a += 2) begin
            rd(5'(a), 5'(a + 1));
            #1;
            chk($sformatf("post_r%0d", a),
                R_Data[31:0], 32'(a));
            chk($sformatf("post_r%0d", a + 1),
                R_Data[63:32], 32'(a + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
